// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and frame field widths for the boot loader
package imem_loader_pkg;
    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: gathers little-endian bytes into 32-bit words and flags the 4th byte
// Ports: clk, rst (async active-low), clr (drop partial word), push (byte accepted),
//        data (byte), word_valid (combinational, high while lane 3 is pushed), word (assembled word)
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                push,
    input  logic [BYTE_W-1:0]   data,
    output logic                word_valid,
    output logic [4*BYTE_W-1:0] word
);
    logic [1:0]            byte_cnt;
    logic [3*BYTE_W-1:0]   lanes;
    // Lanes shift down from the top so b0 ends up in the low byte after three pushes
    assign word_valid = push && byte_cnt == 2'd3;
    assign word       = {data, lanes};
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (push) begin
            byte_cnt <= byte_cnt + 2'd1;
            lanes    <= {data, lanes[3*BYTE_W-1:BYTE_W]};
        end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader writing instruction memory and gating core reset
// Ports: clk, rst (async active-low), start (restart from DONE/ERR), in_valid/in_data/in_ready
//        (byte stream), imem_we/imem_addr/imem_wdata (imem write port), cpu_hold (core reset),
//        done (image verified), error (bad length or checksum)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    state_t             state;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   word_idx;
    logic [BYTE_W-1:0]  csum;
    logic               acc;
    logic               word_valid;
    logic [31:0]        word;
    logic [LEN_W-1:0]   n;
    assign in_ready = state != DONE && state != ERR;
    assign acc      = in_valid && in_ready;
    assign n        = {in_data, len[BYTE_W-1:0]};
    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start && !in_ready),
        .push       (acc && state == DATA),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= LEN0;
            len        <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN0: if (acc) begin
                    len[BYTE_W-1:0] <= in_data;
                    state           <= LEN1;
                end
                LEN1: if (acc) begin
                    len[LEN_W-1:BYTE_W] <= in_data;
                    if (n == '0 || 32'(n) > MAX_WORDS) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else
                        state <= DATA;
                end
                DATA: if (acc) begin
                    csum <= csum ^ in_data;
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                        imem_wdata <= word;
                        word_idx   <= word_idx + 16'd1;
                        if (word_idx + 16'd1 == len)
                            state <= CSUM;
                    end
                end
                CSUM: if (acc) begin
                    if (in_data == csum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
                DONE, ERR: if (start) begin
                    state    <= LEN0;
                    len      <= '0;
                    word_idx <= '0;
                    csum     <= '0;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                    error    <= 1'b0;
                end
                default: state <= LEN0;
            endcase
        end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for the boot loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_addr, imem_wdata;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    int          last_acc = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          ea_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        chk("in_ready_before_byte", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send(w[8*i +: 8], maxgap > 0 ? int'($urandom_range(1, maxgap)) : 0);
        ea_q.push_back(last_acc);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        chk("write_present", 32'(wa_q.size() != 0), 32'd1);
        if (wa_q.size() != 0) begin
            chk("write_addr", wa_q.pop_front(), a);
            chk("write_data", wd_q.pop_front(), d);
            chk("write_latency", 32'(wc_q.pop_front()), 32'(ea_q.size() != 0 ? ea_q.pop_front() : -1));
        end
    endtask

    task automatic expect_no_more();
        chk("no_extra_writes", 32'(wa_q.size()), 32'd0);
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        ea_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic h, input logic r);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset_we", 32'(imem_we), 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_wdata", imem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        send(8'h02, 0); send(8'h00, 0);
        send_word(32'h0010_0513, 0);
        send_word(32'h0020_0593, 0);
        chk_status("good_pre_csum", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hB0, 0);
        chk_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_write(32'h0, 32'h0010_0513);
        expect_write(32'h4, 32'h0020_0593);
        expect_no_more();

        pulse_start();
        chk_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h01, 0); send(8'h00, 0);
        chk("restart_hold_mid_load", 32'(cpu_hold), 32'd1);
        send_word(32'hDEAD_BEEF, 0);
        send(8'h22, 0);
        chk_status("restart_done", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_write(32'h0, 32'hDEAD_BEEF);
        expect_no_more();

        pulse_start();
        send(8'h02, 2); send(8'h00, 1);
        send_word(32'h0010_0513, 5);
        send_word(32'h0020_0593, 5);
        send(8'hB1, 3);
        chk_status("badcsum", 1'b0, 1'b1, 1'b1, 1'b0);
        expect_write(32'h0, 32'h0010_0513);
        expect_write(32'h4, 32'h0020_0593);
        in_valid = 1'b1;
        in_data  = 8'hB0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk_status("extra_byte", 1'b0, 1'b1, 1'b1, 1'b0);
        expect_no_more();

        pulse_start();
        chk("zero_len_error_cleared", 32'(error), 32'd0);
        send(8'h00, 0); send(8'h00, 0);
        chk_status("zero_len", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        expect_no_more();

        pulse_start();
        send(8'h05, 0); send(8'h00, 0);
        chk_status("over_max", 1'b0, 1'b1, 1'b1, 1'b0);
        expect_no_more();

        pulse_start();
        send(8'h04, 0); send(8'h00, 0);
        chk_status("max_len_accepted", 1'b0, 1'b0, 1'b1, 1'b1);
        send_word(32'h3423_1201, 0);
        send_word(32'h7867_5645, 2);
        send_word(32'hBCAB_9A89, 0);
        send_word(32'h00EF_DECD, 0);
        send(8'hF0, 0);
        chk_status("max_len_done", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_write(32'h0, 32'h3423_1201);
        expect_write(32'h4, 32'h7867_5645);
        expect_write(32'h8, 32'hBCAB_9A89);
        expect_write(32'hC, 32'h00EF_DECD);
        expect_no_more();

        pulse_start();
        send(8'h02, 0); send(8'h00, 0);
        send_word(32'h0010_0513, 0);
        #2 rst = 1'b0;
        #1;
        chk_status("mid_reset", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mid_reset_we", 32'(imem_we), 32'd0);
        chk("mid_reset_addr", imem_addr, 32'd0);
        chk("mid_reset_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_status("after_reset", 1'b0, 1'b0, 1'b1, 1'b1);
        expect_write(32'h0, 32'h0010_0513);
        expect_no_more();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
